// File: rtl/enc_pwm_pkg.sv
// Shared types for the quadrature encoder to PWM array.
// Quadrature phase encoding and the per-sample step decoder.
package enc_pwm_pkg;

    localparam int DEF_N_CH     = 2;
    localparam int DEF_POS_W    = 10;
    localparam int DEF_FILT_LEN = 3;
    localparam int DEF_DIV_W    = 24;

    localparam logic [1:0] Q_IDLE = 2'b00;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_INC,
        STEP_DEC,
        STEP_ILL
    } step_e;

    // Gray {A,B} to phase index: 00->0, 01->1, 11->2, 10->3
    function automatic logic [1:0] q_phase(logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    function automatic step_e step_of(logic [1:0] prev,
                                      logic [1:0] cur);
        logic [1:0] d;
        d = q_phase(cur) - q_phase(prev);
        unique case (d)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_INC;
            2'd3:    return STEP_DEC;
            default: return STEP_ILL;
        endcase
    endfunction

endpackage

// File: rtl/enc_pwm_if.sv
// Pin/config bundle between encoder pins, switch logic and PWM pins.
// The master side drives config and encoder levels.
interface enc_pwm_if #(
    parameter int N_CH  = 2,
    parameter int POS_W = 10,
    parameter int DIV_W = 24
);
    logic [POS_W-1:0]      ppr;
    logic [DIV_W-1:0]      rate_div;
    logic [N_CH-1:0]       enc_a;
    logic [N_CH-1:0]       enc_b;
    logic                  clr_err;
    logic [N_CH*POS_W-1:0] pos_out;
    logic [N_CH-1:0]       pwm;
    logic [N_CH-1:0]       dir_err;

    modport master (
        output ppr, rate_div, enc_a, enc_b, clr_err,
        input  pos_out, pwm, dir_err
    );

    modport slave (
        input  ppr, rate_div, enc_a, enc_b, clr_err,
        output pos_out, pwm, dir_err
    );
endinterface

// File: rtl/enc_pwm_chan.sv
// One channel: sync, glitch filter, x4 decode, position, duty compare.
// ENC_PWM_ERR_EN enables the sticky illegal-transition flag.
module enc_pwm_chan
    import enc_pwm_pkg::*;
#(
    parameter int POS_W    = DEF_POS_W,
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr_err,
    input  logic [POS_W-1:0] ppr,
    input  logic [POS_W-1:0] cnt,
    input  logic             run,
    input  logic             load,
    output logic [POS_W-1:0] pos,
    output logic             pwm,
    output logic             dir_err
);
    localparam logic [3:0] FL_M1 = 4'(FILT_LEN - 1);

    logic [1:0]      s1, s2, filt, prev;
    logic [1:0][3:0] fcnt;
    logic [POS_W-1:0] duty, ppr_m1;
    step_e           step;

    assign ppr_m1 = ppr - 1'b1;
    assign step   = step_of(prev, filt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= Q_IDLE;
            s2 <= Q_IDLE;
        end else begin
            s1 <= {enc_a, enc_b};
            s2 <= s1;
        end
    end

    // Level accepted after FILT_LEN consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt <= Q_IDLE;
            fcnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (s2[k] == filt[k]) begin
                    fcnt[k] <= '0;
                end else if (fcnt[k] == FL_M1) begin
                    filt[k] <= s2[k];
                    fcnt[k] <= '0;
                end else begin
                    fcnt[k] <= fcnt[k] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= Q_IDLE;
        end else begin
            prev <= filt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos <= '0;
        end else if (!run) begin
            pos <= '0;
        end else if (pos >= ppr) begin
            pos <= ppr_m1;
        end else begin
            case (step)
                STEP_INC: pos <= (pos == ppr_m1) ? '0 : pos + 1'b1;
                STEP_DEC: pos <= (pos == '0) ? ppr_m1 : pos - 1'b1;
                default:  pos <= pos;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else if (!run) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            if (load) duty <= pos;
            pwm <= (cnt < duty);
        end
    end

`ifdef ENC_PWM_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_err <= 1'b0;
        end else if (step == STEP_ILL) begin
            dir_err <= 1'b1;
        end else if (clr_err) begin
            dir_err <= 1'b0;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_err;
    assign dir_err    = 1'b0;
`endif

endmodule

// File: rtl/enc_pwm_array.sv
// N-channel quadrature encoder to PWM engine with shared timebase.
// Build option ENC_PWM_ERR_EN enables per-channel dir_err.
module enc_pwm_array
    import enc_pwm_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int POS_W    = DEF_POS_W,
    parameter int FILT_LEN = DEF_FILT_LEN,
    parameter int DIV_W    = DEF_DIV_W
) (
    input logic      clk,
    input logic      reset,
    enc_pwm_if.slave bus
);
    logic [DIV_W-1:0] presc;
    logic [POS_W-1:0] cnt;
    logic             tick, run, wrap;

    assign run  = bus.ppr > POS_W'(1);
    assign tick = (presc == '0);
    assign wrap = run && tick && (cnt >= bus.ppr - 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= bus.rate_div;
        end else begin
            presc <= presc - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        enc_pwm_chan #(
            .POS_W    (POS_W),
            .FILT_LEN (FILT_LEN)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .enc_a   (bus.enc_a[i]),
            .enc_b   (bus.enc_b[i]),
            .clr_err (bus.clr_err),
            .ppr     (bus.ppr),
            .cnt     (cnt),
            .run     (run),
            .load    (wrap),
            .pos     (bus.pos_out[i*POS_W +: POS_W]),
            .pwm     (bus.pwm[i]),
            .dir_err (bus.dir_err[i])
        );
    end

endmodule

// File: tb/tb_enc_pwm_array.sv
// Scoreboard bench for enc_pwm_array.
// Expected values queued at stimulus time, popped at observation.
module tb_enc_pwm_array;

    localparam int N_CH     = 2;
    localparam int POS_W    = 10;
    localparam int FILT_LEN = 3;
    localparam int DIV_W    = 24;
    localparam int HOLD     = FILT_LEN + 4;
    localparam int LIM      = 8000;
`ifdef ENC_PWM_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    enc_pwm_if #(.N_CH(N_CH), .POS_W(POS_W), .DIV_W(DIV_W)) bus ();

    enc_pwm_array #(
        .N_CH     (N_CH),
        .POS_W    (POS_W),
        .FILT_LEN (FILT_LEN),
        .DIV_W    (DIV_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    qidx[N_CH];
    string tag_q[$];
    int    exp_q[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(string tag, int val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic sb_pop(logic [31:0] got);
        string t;
        int    e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got %0d expected none", got);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, got, e);
        end
    endtask

    function automatic int pos_of(int ch);
        return int'(bus.pos_out[ch*POS_W +: POS_W]);
    endfunction

    function automatic logic [1:0] gray(int i);
        case (i & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic set_ab(int ch, logic [1:0] ab);
        bus.enc_a[ch] = ab[1];
        bus.enc_b[ch] = ab[0];
    endtask

    task automatic step(int ch, int dir);
        qidx[ch] = (qidx[ch] + dir) & 3;
        set_ab(ch, gray(qidx[ch]));
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic meas(int ch, output int hi, output int per);
        int t;
        hi  = -1;
        per = -1;
        t   = 0;
        while (bus.pwm[ch] !== 1'b0 && t < LIM) begin
            @(negedge clk); t++;
        end
        while (bus.pwm[ch] !== 1'b1 && t < LIM) begin
            @(negedge clk); t++;
        end
        if (t >= LIM) return;
        hi = 0;
        per = 0;
        while (bus.pwm[ch] === 1'b1 && t < LIM) begin
            hi++; per++; @(negedge clk); t++;
        end
        while (bus.pwm[ch] !== 1'b1 && t < LIM) begin
            per++; @(negedge clk); t++;
        end
        if (t >= LIM) per = -1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hi, per, t, nh;
        bus.ppr      = 10'd600;
        bus.rate_div = 24'd3;
        bus.enc_a    = '0;
        bus.enc_b    = '0;
        bus.clr_err  = 1'b0;
        for (int i = 0; i < N_CH; i++) qidx[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_pos", bus.pos_out, 0);
        chk("rst_pwm", bus.pwm, 0);
        chk("rst_err", bus.dir_err, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        sb_push("rel_pos0", 0);
        sb_push("rel_pwm", 0);
        sb_pop(pos_of(0));
        sb_pop(bus.pwm);

        // First step checks exact latency, then 39 more
        qidx[0] = 1;
        set_ab(0, gray(1));
        repeat (FILT_LEN + 2) @(negedge clk);
        chk("lat_early", pos_of(0), 0);
        @(negedge clk);
        chk("lat_edge", pos_of(0), 1);
        for (int i = 0; i < 39; i++) step(0, 1);
        sb_push("fwd_pos0", 40);
        sb_push("idle_pos1", 0);
        sb_pop(pos_of(0));
        sb_pop(pos_of(1));

        sb_push("hi_40", 160);
        sb_push("per_600", 2400);
        meas(0, hi, per);
        sb_pop(hi);
        sb_pop(per);

        t = 0;
        while (bus.pwm[0] !== 1'b1 && t < LIM) begin
            @(negedge clk); t++;
        end
        chk("pwm_seen_high", bus.pwm[0], 1);
        set_ab(0, 2'b00);
        qidx[0] = 0;
        reset = 1'b0;
        #1;
        chk("async_pwm", bus.pwm[0], 0);
        chk("async_pos", pos_of(0), 0);
        @(negedge clk);
        reset = 1'b1;
        bus.ppr = 10'd64;
        repeat (2) @(negedge clk);

        sb_push("rev_wrap", 63);
        step(0, -1);
        sb_pop(pos_of(0));
        sb_push("fwd_wrap", 0);
        step(0, 1);
        sb_pop(pos_of(0));

        bus.enc_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        bus.enc_a[0] = 1'b0;
        sb_push("glitch_pos", 0);
        sb_push("glitch_err", 0);
        repeat (10) @(negedge clk);
        sb_pop(pos_of(0));
        sb_pop(bus.dir_err);

        qidx[1] = 2;
        set_ab(1, 2'b11);
        sb_push("ill_pos1", 0);
        sb_push("ill_err1", ERR_EN);
        repeat (HOLD) @(negedge clk);
        sb_pop(pos_of(1));
        sb_pop(bus.dir_err[1]);
        chk("ill_err0", bus.dir_err[0], 0);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("clr_err1", bus.dir_err[1], 0);

        // Clear lands on the same edge as a second illegal step
        qidx[1] = 0;
        set_ab(1, 2'b00);
        repeat (FILT_LEN + 2) @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("set_wins", bus.dir_err[1], ERR_EN);
        chk("set_wins_pos", pos_of(1), 0);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("clr2_err1", bus.dir_err[1], 0);

        bus.ppr = 10'd600;
        for (int i = 0; i < 500; i++) step(0, 1);
        sb_push("pos_500", 500);
        sb_pop(pos_of(0));
        bus.ppr = 10'd256;
        sb_push("clamp_255", 255);
        @(negedge clk);
        sb_pop(pos_of(0));

        meas(0, hi, per);
        sb_push("hi_255", 1020);
        sb_push("per_256", 1024);
        meas(0, hi, per);
        sb_pop(hi);
        sb_pop(per);

        bus.ppr = 10'd1;
        repeat (2) @(negedge clk);
        chk("ppr1_pos", pos_of(0), 0);
        nh = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.pwm !== '0) nh++;
            @(negedge clk);
        end
        chk("ppr1_pwm", nh, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
